out_layer_mac_seq: RTL and testbench

//  Sequences the output-layer weight memory (10 neurons x 30 packed 8-bit weights) through one shared multiply-accumulator.

---
 rtl/out_layer_mac_seq.sv | 205 ++++++++++++++++++++
 tb/tb_out_layer_mac_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_layer_mac_seq.sv
// -----------------------------------------------------------------------------
// out_layer_mac_seq
//
// Output-layer sequencer. It sends a 10-neuron x N_HID weight memory through
// one shared multiply-accumulator.
//   - On start, the hidden activations are copied into a snapshot register.
//   - Each neuron's dot product is then built at one weight per clock cycle.
//   - The 10 results leave in neuron order over a valid/ready stream.
//
// Weights are sign-magnitude: bit DW-1 is the sign, the low DW-1 bits are the
// magnitude. Activations are unsigned.
//
// Optional feature macro: FNN_ARGMAX_EN
//   defined   : a running signed maximum over the emitted results drives
//               class_idx. class_idx is updated on the done cycle. Ties keep
//               the lower neuron index.
//   undefined : class_idx is tied to 0.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous active-low reset
//   start      in   1            begin inference; only accepted in IDLE
//   hid_act    in   N_HID*DW     activation j at bits [DW*j +: DW]
//   wo0..wo9   in   N_HID*DW     neuron weights, same packing; static per run
//   busy       out  1            run in progress
//   out_valid  out  1            result available
//   out_ready  in   1            consumer accepts result
//   out_idx    out  4            neuron index of out_acc
//   out_acc    out  ACC_W        signed dot product
//   done       out  1            one-cycle pulse after the 10th handshake
//   class_idx  out  4            argmax neuron (0 when FNN_ARGMAX_EN undefined)
// -----------------------------------------------------------------------------
module out_layer_mac_seq #(
    parameter int N_HID = 30,
    parameter int DW    = 8,
    parameter int ACC_W = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_HID*DW-1:0]     hid_act,
    input  logic [N_HID*DW-1:0]     wo0,
    input  logic [N_HID*DW-1:0]     wo1,
    input  logic [N_HID*DW-1:0]     wo2,
    input  logic [N_HID*DW-1:0]     wo3,
    input  logic [N_HID*DW-1:0]     wo4,
    input  logic [N_HID*DW-1:0]     wo5,
    input  logic [N_HID*DW-1:0]     wo6,
    input  logic [N_HID*DW-1:0]     wo7,
    input  logic [N_HID*DW-1:0]     wo8,
    input  logic [N_HID*DW-1:0]     wo9,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_idx,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    done,
    output logic [3:0]              class_idx
);

    localparam int N_OUT = 10;
    localparam int JW    = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int PW    = 2 * DW - 1;   // unsigned magnitude-product width

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_t;

    state_t                    state;
    logic [N_HID*DW-1:0]       act_snap;
    logic [3:0]                nrn;
    logic [JW-1:0]             tap;
    logic signed [ACC_W-1:0]   acc;

    logic [N_HID*DW-1:0]       w_bus;
    logic [DW-1:0]             w_sel;
    logic [DW-1:0]             a_sel;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   acc_sum;

    // Sign-magnitude weight times unsigned activation.
    // A weight of 0x80 (negative zero) yields 0.
    function automatic logic signed [ACC_W-1:0] sm_prod(input logic [DW-1:0] w,
                                                        input logic [DW-1:0] a);
        logic [PW-1:0]           mag;
        logic signed [ACC_W-1:0] ext;
        mag = {{DW{1'b0}}, w[DW-2:0]} * {{(DW-1){1'b0}}, a};
        ext = signed'({{(ACC_W-PW){1'b0}}, mag});
        return w[DW-1] ? -ext : ext;
    endfunction

    always_comb begin
        w_bus = '0;
        case (nrn)
            4'd0:    w_bus = wo0;
            4'd1:    w_bus = wo1;
            4'd2:    w_bus = wo2;
            4'd3:    w_bus = wo3;
            4'd4:    w_bus = wo4;
            4'd5:    w_bus = wo5;
            4'd6:    w_bus = wo6;
            4'd7:    w_bus = wo7;
            4'd8:    w_bus = wo8;
            default: w_bus = wo9;
        endcase
    end

    assign w_sel   = w_bus[tap*DW +: DW];
    assign a_sel   = act_snap[tap*DW +: DW];
    assign prod    = sm_prod(w_sel, a_sel);
    assign acc_sum = acc + prod;

    // Only the control state and the visible outputs are reset. The snapshot,
    // the counters and the accumulator are all loaded on start accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_idx   <= '0;
            out_acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        act_snap <= hid_act;
                        nrn      <= '0;
                        tap      <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (tap == JW'(N_HID - 1)) begin
                        out_acc   <= acc_sum;
                        out_idx   <= nrn;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        acc <= acc_sum;
                        tap <= tap + JW'(1);
                    end
                end
                S_EMIT: begin
                    // out_valid is always 1 here, so out_ready alone completes the handshake
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (nrn == 4'(N_OUT - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            nrn   <= nrn + 4'd1;
                            tap   <= '0;
                            acc   <= '0;
                            state <= S_MAC;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FNN_ARGMAX_EN
    logic signed [ACC_W-1:0] max_acc;
    logic [3:0]              max_idx;
    logic                    has_max;
    logic                    accept;
    logic                    hs;
    logic                    beats_max;

    assign accept    = (state == S_IDLE) && start;
    assign hs        = (state == S_EMIT) && out_ready;
    // The first result of a run always seeds the max. After that, only a
    // strictly greater result replaces it, so a tie keeps the lower index.
    assign beats_max = !has_max || (out_acc > max_acc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_acc   <= '0;
            max_idx   <= '0;
            has_max   <= 1'b0;
            class_idx <= '0;
        end else if (accept) begin
            has_max <= 1'b0;
        end else if (hs) begin
            if (beats_max) begin
                max_acc <= out_acc;
                max_idx <= out_idx;
                has_max <= 1'b1;
            end
            // The last result must be included, so class_idx is resolved on
            // the final handshake. It is therefore valid in the cycle where done=1.
            if (nrn == 4'(N_OUT - 1)) begin
                class_idx <= beats_max ? out_idx : max_idx;
            end
        end
    end
`else
    assign class_idx = '0;
`endif

endmodule

// File: tb/tb_out_layer_mac_seq.sv
`timescale 1ns/1ps
module tb_out_layer_mac_seq;

    localparam int N_HID = 30;
    localparam int DW    = 8;
    localparam int ACC_W = 21;
    localparam int BW    = N_HID * DW;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    out_ready = 1'b1;
    logic [BW-1:0]           hid_act = '0;
    logic [BW-1:0]           wo0 = '0, wo1 = '0, wo2 = '0, wo3 = '0, wo4 = '0;
    logic [BW-1:0]           wo5 = '0, wo6 = '0, wo7 = '0, wo8 = '0, wo9 = '0;
    logic                    busy, out_valid, done;
    logic [3:0]              out_idx, class_idx;
    logic signed [ACC_W-1:0] out_acc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;
    int ea[10];

    typedef struct { int idx; int acc; } res_t;
    typedef struct { int cls; int t0; int lat; } dn_t;
    res_t exp_q[$];
    dn_t  done_q[$];

    out_layer_mac_seq #(.N_HID(N_HID), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hid_act(hid_act),
        .wo0(wo0), .wo1(wo1), .wo2(wo2), .wo3(wo3), .wo4(wo4),
        .wo5(wo5), .wo6(wo6), .wo7(wo7), .wo8(wo8), .wo9(wo9),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_acc(out_acc), .done(done), .class_idx(class_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BW-1:0] rep(input logic [7:0] b);
        logic [BW-1:0] r;
        r = '0;
        for (int j = 0; j < N_HID; j++) r[j*DW +: DW] = b;
        return r;
    endfunction

    // weight/activation j = j, with optional sign bit
    function automatic logic [BW-1:0] ramp(input logic s);
        logic [BW-1:0] r;
        r = '0;
        for (int j = 0; j < N_HID; j++) r[j*DW +: DW] = {s, 7'(j)};
        return r;
    endfunction

    function automatic int exp_cls(input int c);
`ifdef FNN_ARGMAX_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_valid(input int idx, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_idx == 4'(idx)) && n < budget);
        if (!(out_valid && out_idx == 4'(idx))) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_idx%0d: none within %0d cycles, required a result", idx, budget);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL wait_done: done count %0d, required %0d", done_cnt, target);
        end
    endtask

    // called at a negedge; start is sampled at the following posedge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check("busy_after_start", busy, 1);
    endtask

    task automatic push_run(input int e[10], input int cls, input int lat);
        for (int i = 0; i < 10; i++) exp_q.push_back('{i, e[i]});
        done_q.push_back('{cls, t0, lat});
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_acc"}, out_acc, 0);
        check({tag, "_class_idx"}, class_idx, 0);
    endtask

    task automatic set_w1();
        wo0 = rep(8'h01); wo1 = rep(8'h81); wo2 = rep(8'h7F); wo3 = rep(8'hFF);
        wo4 = rep(8'h80); wo5 = rep(8'h02); wo6 = rep(8'h00); wo7 = rep(8'h03);
        wo8 = ramp(1'b0); wo9 = ramp(1'b1);
    endtask

    // Monitor and scoreboard. It samples 1 ns after the falling edge, so any
    // stimulus driven at that edge is already settled.
    initial begin : monitor
        bit   stall_prev;
        bit   done_prev;
        int   hold_idx;
        int   hold_acc;
        int   per_run;
        res_t e;
        dn_t  d;
        stall_prev = 0; done_prev = 0; hold_idx = 0; hold_acc = 0; per_run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                stall_prev = 0;
                done_prev  = 0;
                per_run    = 0;
                continue;
            end
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_idx", out_idx, hold_idx);
                check("stall_acc", out_acc, hold_acc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got idx %0d acc %0d, required none", out_idx, out_acc);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("res_idx%0d", e.idx), out_idx, e.idx);
                    check($sformatf("res_acc%0d", e.idx), out_acc, e.acc);
                    per_run++;
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_idx   = out_idx;
            hold_acc   = int'(out_acc);
            if (done) begin
                done_cnt++;
                check("done_single_cycle", done_prev, 0);
                check("results_per_run", per_run, 10);
                per_run = 0;
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done, required none");
                end else begin
                    d = done_q.pop_front();
                    check("class_idx_at_done", class_idx, exp_cls(d.cls));
                    check("done_latency", cyc - d.t0, d.lat);
                end
            end
            done_prev = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle_zero("reset");

        // Run A: all activations 1, uniform and ramp weights. Back-to-back start into run C.
        set_w1();
        hid_act = rep(8'h01);
        pulse_start();
        ea = '{30, -30, 3810, -3810, 0, 60, 0, 90, 435, -435};
        push_run(ea, 2, 310);
        wait_valid(0, 60);
        check("latency_first", cyc - t0, 30);
        wait_valid(1, 60);
        check("latency_second", cyc - t0, 61);
        wait_valid(9, 400);
        @(negedge clk);                     // done cycle: start is accepted here
        hid_act = rep(8'hFF);
        pulse_start();

        // Run C: activations 0xFF. Ignored start pulses, a snapshot change and a 5-cycle stall.
        ea = '{7650, -7650, 971550, -971550, 0, 15300, 0, 22950, 110925, -110925};
        push_run(ea, 2, 315);
        repeat (10) @(negedge clk);
        start = 1'b1;
        hid_act = rep(8'h01);
        @(negedge clk);
        start = 1'b0;
        wait_valid(3, 200);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        wait_done(2, 600);
        @(negedge clk);
        check("class_idx_hold", class_idx, exp_cls(2));
        check("busy_after_done", busy, 0);

        // Run B: reset during neuron 5 accumulation
        hid_act = rep(8'h01);
        pulse_start();
        ea = '{30, -30, 3810, -3810, 0, 60, 0, 90, 435, -435};
        push_run(ea, 2, 310);
        wait_valid(4, 300);
        repeat (10) @(negedge clk);
        exp_q.delete();
        done_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_zero("midrun_reset");

        // Run D: activation ramp; neuron 7 is the largest (neuron 9 ties it later)
        hid_act = ramp(1'b0);
        wo0 = rep(8'h01); wo1 = rep(8'h81); wo2 = rep(8'h04); wo3 = rep(8'h90);
        wo4 = rep(8'h80); wo5 = rep(8'h03); wo6 = rep(8'h0F); wo7 = rep(8'h10);
        wo8 = ramp(1'b1); wo9 = rep(8'h10);
        pulse_start();
        ea = '{435, -435, 1740, -6960, 0, 1305, 6525, 6960, -8555, 6960};
        push_run(ea, 7, 310);
        wait_done(3, 600);

        // Run E: neurons 2 and 5 tie for the max
        hid_act = rep(8'h01);
        wo0 = rep(8'h01); wo1 = rep(8'h81); wo2 = rep(8'h40); wo3 = rep(8'hC0);
        wo4 = rep(8'h80); wo5 = rep(8'h40); wo6 = rep(8'h3F); wo7 = rep(8'h02);
        wo8 = ramp(1'b0); wo9 = ramp(1'b1);
        @(negedge clk);
        pulse_start();
        ea = '{30, -30, 1920, -1920, 0, 1920, 1890, 60, 435, -435};
        push_run(ea, 2, 310);
        wait_done(4, 600);

        // Run F: all results negative; the max is the last neuron
        wo0 = rep(8'h8A); wo1 = rep(8'h89); wo2 = rep(8'h88); wo3 = rep(8'h87);
        wo4 = rep(8'h86); wo5 = rep(8'h85); wo6 = rep(8'h84); wo7 = rep(8'h83);
        wo8 = rep(8'h82); wo9 = rep(8'h81);
        @(negedge clk);
        pulse_start();
        ea = '{-300, -270, -240, -210, -180, -150, -120, -90, -60, -30};
        push_run(ea, 9, 310);
        wait_done(5, 600);

        repeat (3) @(negedge clk);
        check("results_left", exp_q.size(), 0);
        check("dones_left", done_q.size(), 0);
        check("done_count", done_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
